// File: rtl/alu_pkg.sv
// alu_pkg: shared width, op-code and iteration-state types for the ALU execution unit
package alu_pkg;
  localparam int ALU_WIDTH = 32;
  typedef enum logic [4:0] {
    OP_XOR = 5'd0, OP_SLL, OP_SLLV, OP_SRL, OP_SUB, OP_SRLV, OP_SLT, OP_HALT,
    OP_SUBU, OP_OR, OP_NOR, OP_ADDU, OP_MUL, OP_DIV, OP_AND, OP_ADD,
    OP_JR, OP_SRA, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_BGEZ,
    OP_LW, OP_SW, OP_LB, OP_SB, OP_SLTI, OP_LUI
  } alu_op_e;
  typedef enum logic [1:0] {IDLE, MUL, DIV, SIGNFIX} alu_state_e;
endpackage

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: radix-2 shift-add multiply and restoring signed divide, one bit per cycle
// (built only when ALU_MULDIV_EN is defined)
module alu_muldiv_iter import alu_pkg::*; #(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_mul_i,
  input  logic             start_div_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);
  localparam int CW = $clog2(WIDTH);
  alu_state_e state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [WIDTH-1:0] p_q, x_q, y_q, mul_sum, div_p, div_x;
  logic [WIDTH:0] r_sh, r_diff;
  logic neg_q, last;
  // p: product accumulator / partial remainder; x: multiplicand / dividend->quotient; y: multiplier / divisor
  assign last = cnt_q == CW'(WIDTH - 1);
  assign mul_sum = p_q + (y_q[0] ? x_q : '0);
  assign r_sh = {p_q, x_q[WIDTH-1]};
  assign r_diff = r_sh - {1'b0, y_q};
  assign div_p = r_diff[WIDTH] ? r_sh[WIDTH-1:0] : r_diff[WIDTH-1:0];
  assign div_x = {x_q[WIDTH-2:0], ~r_diff[WIDTH]};
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start_mul_i ? MUL : start_div_i ? DIV : IDLE;
      MUL:     state_d = last ? IDLE : MUL;
      DIV:     state_d = last ? SIGNFIX : DIV;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    busy_o = state_q != IDLE;
    done_o = (state_q == MUL && last) || state_q == SIGNFIX;
    result_o = state_q == MUL ? mul_sum : neg_q ? -x_q : x_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      p_q <= '0;
      x_q <= '0;
      y_q <= '0;
      neg_q <= 1'b0;
    end else if (start_mul_i || start_div_i) begin
      cnt_q <= '0;
      p_q <= '0;
      x_q <= (start_div_i && a_i[WIDTH-1]) ? -a_i : a_i;
      y_q <= (start_div_i && b_i[WIDTH-1]) ? -b_i : b_i;
      neg_q <= a_i[WIDTH-1] ^ b_i[WIDTH-1];
    end else if (state_q == MUL) begin
      p_q <= mul_sum;
      x_q <= x_q << 1;
      y_q <= y_q >> 1;
      cnt_q <= cnt_q + 1'b1;
    end else if (state_q == DIV) begin
      p_q <= div_p;
      x_q <= div_x;
      cnt_q <= cnt_q + 1'b1;
    end
  end
endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: single-cycle ALU/branch/address ops with registered result and ready pulse;
// iterative MUL/DIV present only when ALU_MULDIV_EN is defined
module alu_exec_unit import alu_pkg::*; #(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [5:0]       aluctl,
  output logic             busy,
  output logic             alu_ready,
  output logic [WIDTH-1:0] alu_out_data,
  output logic             overflow,
  output logic             div_by_zero
);
  localparam int SW = $clog2(WIDTH);
  alu_op_e op;
  logic [WIDTH-1:0] sum, diff, res, out_q, it_res;
  logic [SW-1:0] sh;
  logic ovf, dbz, ready_q, ovf_q, dbz_q, accept, it_start_mul, it_start_div, it_busy, it_done;
  logic unused_itag;
  assign op = alu_op_e'(aluctl[5:1]);
  assign unused_itag = aluctl[0];
  assign sh = B[SW-1:0];
  assign sum = A + B;
  assign diff = A - B;
  assign accept = start & ~busy;
  always_comb begin
    res = '0;
    ovf = 1'b0;
    dbz = 1'b0;
    case (op)
      OP_XOR:                     res = A ^ B;
      OP_SLL, OP_SLLV:            res = A << sh;
      OP_SRL, OP_SRLV:            res = A >> sh;
      OP_SUB: begin
        res = diff;
        ovf = (A[WIDTH-1] ^ B[WIDTH-1]) & (diff[WIDTH-1] ^ A[WIDTH-1]);
      end
      OP_SLT, OP_SLTI:            res = WIDTH'($signed(A) < $signed(B));
      OP_SUBU:                    res = diff;
      OP_OR:                      res = A | B;
      OP_NOR:                     res = ~(A | B);
      OP_ADDU, OP_LW, OP_SW, OP_LB, OP_SB: res = sum;
`ifdef ALU_MULDIV_EN
      OP_DIV: begin
        res = '1;
        dbz = 1'b1;
      end
`endif
      OP_AND:                     res = A & B;
      OP_ADD: begin
        res = sum;
        ovf = ~(A[WIDTH-1] ^ B[WIDTH-1]) & (sum[WIDTH-1] ^ A[WIDTH-1]);
      end
      OP_JR:                      res = A;
      OP_SRA:                     res = $signed(A) >>> sh;
      OP_BEQ:                     res = WIDTH'(A == B);
      OP_BNE:                     res = WIDTH'(A != B);
      OP_BLEZ:                    res = WIDTH'($signed(A) <= 0);
      OP_BGTZ:                    res = WIDTH'($signed(A) > 0);
      OP_BGEZ:                    res = WIDTH'($signed(A) >= 0);
      OP_LUI:                     res = B << 16;
      default:                    res = '0;
    endcase
  end
`ifdef ALU_MULDIV_EN
  // a zero divisor never enters the iterator; it completes through the single-cycle path
  assign it_start_mul = accept & (op == OP_MUL);
  assign it_start_div = accept & (op == OP_DIV) & (B != '0);
  alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk(clk), .rst(rst), .start_mul_i(it_start_mul), .start_div_i(it_start_div),
    .a_i(A), .b_i(B), .busy_o(it_busy), .done_o(it_done), .result_o(it_res)
  );
`else
  assign it_start_mul = 1'b0;
  assign it_start_div = 1'b0;
  assign it_busy = 1'b0;
  assign it_done = 1'b0;
  assign it_res = '0;
`endif
  assign busy = it_busy;
  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q <= 1'b0;
      out_q <= '0;
      ovf_q <= 1'b0;
      dbz_q <= 1'b0;
    end else if (it_done) begin
      ready_q <= 1'b1;
      out_q <= it_res;
      ovf_q <= 1'b0;
      dbz_q <= 1'b0;
    end else if (accept && !it_start_mul && !it_start_div) begin
      ready_q <= 1'b1;
      out_q <= res;
      ovf_q <= ovf;
      dbz_q <= dbz;
    end else begin
      ready_q <= 1'b0;
    end
  end
  assign alu_ready = ready_q;
  assign alu_out_data = out_q;
  assign overflow = ovf_q;
  assign div_by_zero = dbz_q;
endmodule
